// File: rtl/game_turn_ctrl.sv
// rtl/game_turn_ctrl.sv - N-player round-robin turn controller; optional turn timer under GAME_TURN_TIMEOUT_EN
module game_turn_ctrl #(
  parameter int NUM_PLAYERS  = 2,
  parameter int HP_W         = 10,
  parameter int ROUND_W      = 8,
  parameter int TURN_TIMEOUT = 1000000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PLAYERS-1:0]          enter_pressed,
  input  logic [NUM_PLAYERS-1:0]          turn_done,
  input  logic [NUM_PLAYERS*HP_W-1:0]     hp_flat,
  output logic [NUM_PLAYERS-1:0]          turn_onehot,
  output logic [$clog2(NUM_PLAYERS)-1:0]  active_idx,
  output logic [1:0]                      state_out,
  output logic                            start_game,
  output logic                            next_turn,
  output logic [ROUND_W-1:0]              round_cnt,
  output logic                            winner_valid,
  output logic [$clog2(NUM_PLAYERS)-1:0]  winner_idx,
  output logic                            draw,
  output logic                            timeout
);

  localparam int IDX_W  = $clog2(NUM_PLAYERS);
  localparam int IDXP_W = IDX_W + 1;
  localparam int CNT_W  = $clog2(NUM_PLAYERS + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_TURN      = 2'd1,
    S_ADVANCE   = 2'd2,
    S_GAME_OVER = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         active_idx_q, active_idx_d;
  logic [NUM_PLAYERS-1:0]   turn_onehot_q, turn_onehot_d;
  logic                     start_game_q, start_game_d;
  logic                     next_turn_q, next_turn_d;
  logic [ROUND_W-1:0]       round_cnt_q, round_cnt_d;
  logic                     winner_valid_q, winner_valid_d;
  logic [IDX_W-1:0]         winner_idx_q, winner_idx_d;
  logic                     draw_q, draw_d;

  logic [NUM_PLAYERS-1:0]   alive;
  logic [CNT_W-1:0]         alive_cnt;
  logic [IDX_W-1:0]         survivor_idx;
  logic [IDX_W-1:0]         start_idx;
  logic [IDX_W-1:0]         next_idx;
  logic [IDXP_W-1:0]        cand;
  logic                     found;
  logic                     wrap;
  logic                     game_end;

`ifdef GAME_TURN_TIMEOUT_EN
  localparam int TMR_W = $clog2(TURN_TIMEOUT + 1);
  logic [TMR_W-1:0]         timer_q, timer_d;
  logic                     timeout_q, timeout_d;
`endif

  // Liveness of each player, survivor count, lowest survivor and lowest requesting player
  always_comb begin
    alive        = '0;
    alive_cnt    = '0;
    survivor_idx = '0;
    start_idx    = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      alive[i]  = |hp_flat[i*HP_W +: HP_W];
      alive_cnt = alive_cnt + CNT_W'(alive[i]);
    end
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (alive[i]) survivor_idx = IDX_W'(i);
      if (enter_pressed[i]) start_idx = IDX_W'(i);
    end
  end

  // Scan upward from the active player, modulo NUM_PLAYERS, for the next alive player
  always_comb begin
    next_idx = active_idx_q;
    found    = 1'b0;
    cand     = '0;
    for (int k = 1; k < NUM_PLAYERS; k++) begin
      cand = {1'b0, active_idx_q} + IDXP_W'(k);
      if (cand >= IDXP_W'(NUM_PLAYERS)) cand = cand - IDXP_W'(NUM_PLAYERS);
      if (!found && alive[cand[IDX_W-1:0]]) begin
        found    = 1'b1;
        next_idx = cand[IDX_W-1:0];
      end
    end
    wrap = (next_idx <= active_idx_q);
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d      = state_q;
    active_idx_d = active_idx_q;
    round_cnt_d  = round_cnt_q;
    start_game_d = start_game_q;
    winner_idx_d = winner_idx_q;
    draw_d       = draw_q;
    game_end     = (state_q == S_TURN || state_q == S_ADVANCE) && (alive_cnt <= CNT_W'(1));
`ifdef GAME_TURN_TIMEOUT_EN
    timeout_d    = 1'b0;
`endif

    if (game_end) begin
      // Elimination outranks turn handover, timeout and advance
      state_d      = S_GAME_OVER;
      draw_d       = (alive_cnt == '0);
      winner_idx_d = (alive_cnt == '0) ? '0 : survivor_idx;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|enter_pressed) begin
            state_d      = S_TURN;
            active_idx_d = start_idx;
            start_game_d = 1'b1;
            round_cnt_d  = '0;
          end
        end
        S_TURN: begin
          if (turn_done[active_idx_q]) begin
            state_d = S_ADVANCE;
          end
`ifdef GAME_TURN_TIMEOUT_EN
          else if (timer_q == TMR_W'(TURN_TIMEOUT - 1)) begin
            state_d   = S_ADVANCE;
            timeout_d = 1'b1;
          end
`endif
        end
        S_ADVANCE: begin
          state_d      = S_TURN;
          active_idx_d = next_idx;
          if (wrap && (round_cnt_q != {ROUND_W{1'b1}})) round_cnt_d = round_cnt_q + 1'b1;
        end
        S_GAME_OVER: begin
          if (|enter_pressed) begin
            state_d      = S_IDLE;
            start_game_d = 1'b0;
            winner_idx_d = '0;
            draw_d       = 1'b0;
            round_cnt_d  = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    next_turn_d    = (state_d == S_TURN);
    winner_valid_d = (state_d == S_GAME_OVER);
    turn_onehot_d  = (state_d == S_TURN || state_d == S_ADVANCE)
                   ? ({{(NUM_PLAYERS-1){1'b0}}, 1'b1} << active_idx_d) : '0;
`ifdef GAME_TURN_TIMEOUT_EN
    // Timer restarts on every TURN entry and runs only while the turn continues
    timer_d = (state_q == S_TURN && state_d == S_TURN) ? timer_q + 1'b1 : '0;
`endif
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      active_idx_q   <= '0;
      turn_onehot_q  <= '0;
      start_game_q   <= 1'b0;
      next_turn_q    <= 1'b0;
      round_cnt_q    <= '0;
      winner_valid_q <= 1'b0;
      winner_idx_q   <= '0;
      draw_q         <= 1'b0;
`ifdef GAME_TURN_TIMEOUT_EN
      timer_q        <= '0;
      timeout_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      active_idx_q   <= active_idx_d;
      turn_onehot_q  <= turn_onehot_d;
      start_game_q   <= start_game_d;
      next_turn_q    <= next_turn_d;
      round_cnt_q    <= round_cnt_d;
      winner_valid_q <= winner_valid_d;
      winner_idx_q   <= winner_idx_d;
      draw_q         <= draw_d;
`ifdef GAME_TURN_TIMEOUT_EN
      timer_q        <= timer_d;
      timeout_q      <= timeout_d;
`endif
    end
  end

  assign turn_onehot  = turn_onehot_q;
  assign active_idx   = active_idx_q;
  assign state_out    = state_q;
  assign start_game   = start_game_q;
  assign next_turn    = next_turn_q;
  assign round_cnt    = round_cnt_q;
  assign winner_valid = winner_valid_q;
  assign winner_idx   = winner_idx_q;
  assign draw         = draw_q;
`ifdef GAME_TURN_TIMEOUT_EN
  assign timeout      = timeout_q;
`else
  assign timeout      = 1'b0;
`endif

endmodule
